// File: rtl/noc_traffic_defs.sv
// noc_traffic_defs: shared encodings, field offsets and LFSR helpers for the traffic PE
package noc_traffic_defs;
  localparam int PAT_RANDOM = 0;
  localparam int PAT_TRANSPOSE = 1;
  localparam int PAT_COMPLEMENT = 2;
  localparam int PAT_EAST = 3;
  localparam int SEQ_W = 16;
  localparam int CNT_W = 16;
  localparam int SUM_W = 48;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction
  function automatic int ts_lo(input int xs, input int ys);
    return xs + ys;
  endfunction
  function automatic int seq_lo(input int xs, input int ys, input int tsw);
    return xs + ys + tsw;
  endfunction
  function automatic int src_lo(input int xs, input int ys, input int tsw);
    return xs + ys + tsw + SEQ_W;
  endfunction
endpackage

// File: rtl/noc_traffic_sink.sv
// noc_traffic_sink: latency and misroute statistics for packets ejected at this node
module noc_traffic_sink
  import noc_traffic_defs::*;
#(
  parameter int x_size = 1,
  parameter int y_size = 1,
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int TS_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [TS_W-1:0]   cycle_cnt,
  input  logic              w_valid,
  input  logic [x_size-1:0] w_dest_x,
  input  logic [y_size-1:0] w_dest_y,
  input  logic [TS_W-1:0]   w_ts,
  output logic [CNT_W-1:0]  recv_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [SUM_W-1:0]  lat_sum,
  output logic [TS_W-1:0]   lat_max
);
  logic s_valid, s_err;
  logic [TS_W-1:0] s_lat;
  logic [SUM_W:0] sum_n;
  assign sum_n = {1'b0, lat_sum} + (SUM_W+1)'(s_lat);
  // capture stage: latency wraps naturally modulo 2^TS_W
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_valid <= 1'b0;
      s_err <= 1'b0;
      s_lat <= '0;
    end else begin
      s_valid <= w_valid && !clr;
      s_err <= w_dest_x != x_size'(MY_X) || w_dest_y != y_size'(MY_Y);
      s_lat <= cycle_cnt - w_ts;
    end
  // accumulate saturating statistics; misrouted packets still count toward latency
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      recv_count <= '0;
      err_count <= '0;
      lat_sum <= '0;
      lat_max <= '0;
    end else if (clr) begin
      recv_count <= '0;
      err_count <= '0;
      lat_sum <= '0;
      lat_max <= '0;
    end else if (s_valid) begin
      recv_count <= recv_count + CNT_W'(~&recv_count);
      err_count <= err_count + CNT_W'(s_err && !(&err_count));
      lat_sum <= sum_n[SUM_W] ? '1 : sum_n[SUM_W-1:0];
      lat_max <= s_lat > lat_max ? s_lat : lat_max;
    end
endmodule

// File: rtl/noc_traffic_pe.sv
// noc_traffic_pe: rate-controlled packet generator and checking sink for one mesh node
module noc_traffic_pe
  import noc_traffic_defs::*;
#(
  parameter int X = 2,
  parameter int Y = 2,
  parameter int x_size = $clog2(X),
  parameter int y_size = $clog2(Y),
  parameter int data_width = 256,
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int NUM_PACKETS = 1000,
  parameter int RATE = 1,
  parameter int PATTERN = 0,
  parameter int TS_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                enable_send,
  output logic                                r_valid_pe,
  output logic [x_size+y_size+data_width-1:0] r_data_pe,
  input  logic                                r_ready_pe,
  input  logic                                w_valid_pe,
  input  logic [x_size+y_size+data_width-1:0] w_data_pe,
  output logic                                done,
  output logic [CNT_W-1:0]                    sent_count,
  output logic [CNT_W-1:0]                    recv_count,
  output logic [SUM_W-1:0]                    lat_sum,
  output logic [TS_W-1:0]                     lat_max,
  output logic [CNT_W-1:0]                    err_count
);
  localparam int PW = x_size + y_size + data_width;
  localparam int TS_LO = ts_lo(x_size, y_size);
  localparam int SEQ_LO = seq_lo(x_size, y_size, TS_W);
  localparam int SX_LO = src_lo(x_size, y_size, TS_W);
  localparam int SY_LO = SX_LO + x_size;
  localparam int REP = (data_width + 15) / 16;
  localparam int RATE_W = RATE > 1 ? $clog2(RATE) : 1;
  localparam logic [15:0] SEED = LFSR_SEED ^ 16'(MY_Y * X + MY_X);
  state_t state, state_n;
  logic [TS_W-1:0] cycle_cnt;
  logic [15:0] lfsr;
  logic [RATE_W-1:0] rate_cnt;
  logic [SEQ_W-1:0] load_cnt, skip_cnt, slots;
  logic starting, running, space, more, slot, is_self, load, skip, handshake;
  logic [x_size-1:0] rnd_x, fix_x, dest_x;
  logic [y_size-1:0] rnd_y, dest_y;
  logic [REP*16-1:0] fill;
  logic [PW-1:0] pkt;
  logic unused_rx;
  assign unused_rx = ^w_data_pe[PW-1:SEQ_LO];
  assign starting = state == S_IDLE && start;
  assign running = state == S_RUN && start;
  assign space = !r_valid_pe || r_ready_pe;
  assign slots = load_cnt + skip_cnt;
  assign more = slots != SEQ_W'(NUM_PACKETS);
  assign slot = running && enable_send && rate_cnt == '0 && space && more;
  assign is_self = dest_x == x_size'(MY_X) && dest_y == y_size'(MY_Y);
  assign load = slot && !is_self;
  assign skip = slot && is_self;
  assign handshake = r_valid_pe && r_ready_pe;
  // next state: dropping start always returns to idle; run ends once every slot is issued and drained
  always_comb begin
    state_n = !start ? S_IDLE : state == S_IDLE ? S_RUN : (state == S_RUN && !more && space) ? S_DONE : state;
    done = state == S_DONE;
  end
  // destination for the next slot; random picks are folded into range and steered off self
  always_comb begin
    rnd_x = int'(lfsr[x_size-1:0]) >= X ? lfsr[x_size-1:0] - x_size'(X) : lfsr[x_size-1:0];
    rnd_y = int'(lfsr[x_size +: y_size]) >= Y ? lfsr[x_size +: y_size] - y_size'(Y) : lfsr[x_size +: y_size];
    fix_x = (rnd_x == x_size'(MY_X) && rnd_y == y_size'(MY_Y)) ? (int'(rnd_x) == X - 1 ? '0 : rnd_x + x_size'(1)) : rnd_x;
    dest_x = PATTERN == PAT_TRANSPOSE ? x_size'(MY_Y) : PATTERN == PAT_COMPLEMENT ? ~x_size'(MY_X) :
             PATTERN == PAT_EAST ? x_size'((MY_X + 1) % X) : PATTERN == PAT_RANDOM ? fix_x : x_size'(MY_X);
    dest_y = PATTERN == PAT_TRANSPOSE ? y_size'(MY_X) : PATTERN == PAT_COMPLEMENT ? ~y_size'(MY_Y) :
             PATTERN == PAT_EAST ? y_size'(MY_Y) : PATTERN == PAT_RANDOM ? rnd_y : y_size'(MY_Y);
  end
  // assemble the outgoing packet: header fields over an LFSR-filled payload
  always_comb begin
    fill = {REP{lfsr}};
    pkt = {fill[data_width-1:0], dest_y, dest_x};
    pkt[TS_LO +: TS_W] = cycle_cnt;
    pkt[SEQ_LO +: SEQ_W] = load_cnt;
    pkt[SX_LO +: x_size] = x_size'(MY_X);
    pkt[SY_LO +: y_size] = y_size'(MY_Y);
  end
  // free-running timestamp source
  always_ff @(posedge clk or posedge rst)
    if (rst) cycle_cnt <= '0;
    else cycle_cnt <= cycle_cnt + TS_W'(1);
  // run control, rate pacing and the transmit holding register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      lfsr <= SEED;
      rate_cnt <= '0;
      load_cnt <= '0;
      skip_cnt <= '0;
      sent_count <= '0;
      r_valid_pe <= 1'b0;
      r_data_pe <= '0;
    end else begin
      state <= state_n;
      lfsr <= load ? lfsr_next(lfsr) : lfsr;
      rate_cnt <= starting ? '0 : slot ? RATE_W'(RATE - 1) :
                  (running && enable_send && rate_cnt != '0) ? rate_cnt - RATE_W'(1) : rate_cnt;
      load_cnt <= starting ? '0 : load_cnt + SEQ_W'(load);
      skip_cnt <= starting ? '0 : skip_cnt + SEQ_W'(skip);
      sent_count <= starting ? '0 : sent_count + CNT_W'(handshake && !(&sent_count));
      r_valid_pe <= load || (r_valid_pe && !r_ready_pe && start);
      r_data_pe <= load ? pkt : r_data_pe;
    end
  noc_traffic_sink #(
    .x_size(x_size),
    .y_size(y_size),
    .MY_X(MY_X),
    .MY_Y(MY_Y),
    .TS_W(TS_W)
  ) u_sink (
    .clk(clk),
    .rst(rst),
    .clr(starting),
    .cycle_cnt(cycle_cnt),
    .w_valid(w_valid_pe),
    .w_dest_x(w_data_pe[x_size-1:0]),
    .w_dest_y(w_data_pe[x_size +: y_size]),
    .w_ts(w_data_pe[TS_LO +: TS_W]),
    .recv_count(recv_count),
    .err_count(err_count),
    .lat_sum(lat_sum),
    .lat_max(lat_max)
  );
endmodule

// File: tb/tb_noc_traffic_pe.sv
// tb_noc_traffic_pe: scoreboard bench over four 2x2 node-(0,0) configurations
module tb_noc_traffic_pe;
  localparam int TS_W = 32;
  localparam int PW = 258;
  localparam int HW = 52;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start [4], ready [4], en [4], wv [4], vld [4], done [4];
  logic [PW-1:0] wd [4], data [4];
  logic [15:0] sent [4], recv [4], errc [4];
  logic [47:0] lsum [4];
  logic [TS_W-1:0] lmax [4];
  logic [TS_W-1:0] tb_cyc;
  logic [HW-1:0] exp_q [$];
  logic [PW-1:0] save;
  logic [TS_W-1:0] c;
  int sel = 0;
  int n_tests = 0;
  int n_fail = 0;

  // instance 0: east RATE=1 N=4; 1: east RATE=4 N=3; 2: complement N=2; 3: transpose N=3
  for (genvar g = 0; g < 4; g++) begin : g_dut
    noc_traffic_pe #(
      .X(2), .Y(2), .data_width(256), .MY_X(0), .MY_Y(0),
      .NUM_PACKETS(g == 0 ? 4 : g == 2 ? 2 : 3),
      .RATE(g == 1 ? 4 : 1),
      .PATTERN(g == 2 ? 2 : g == 3 ? 1 : 3),
      .TS_W(TS_W)
    ) u (
      .clk(clk), .rst(rst), .start(start[g]), .enable_send(en[g]),
      .r_valid_pe(vld[g]), .r_data_pe(data[g]), .r_ready_pe(ready[g]),
      .w_valid_pe(wv[g]), .w_data_pe(wd[g]), .done(done[g]),
      .sent_count(sent[g]), .recv_count(recv[g]), .lat_sum(lsum[g]),
      .lat_max(lmax[g]), .err_count(errc[g])
    );
  end

  always @(posedge clk or posedge rst)
    if (rst) tb_cyc <= '0;
    else tb_cyc <= tb_cyc + 1;

  function automatic logic [HW-1:0] hdr(input logic dx, input logic dy, input logic [31:0] ts, input logic [15:0] seq);
    return {1'b0, 1'b0, seq, ts, dy, dx};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rx(input logic dx, input logic dy, input logic [31:0] ts);
    wd[0] = '0;
    wd[0][0] = dx;
    wd[0][1] = dy;
    wd[0][33:2] = ts;
    wv[0] = 1'b1;
    @(negedge clk);
    wv[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // monitor: every accepted packet of the selected instance must match the next expected header
  always @(negedge clk) begin
    logic [HW-1:0] e;
    #2;
    if (!rst && vld[sel] && ready[sel]) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pkt_unexpected: got %0h expected none", data[sel][HW-1:0]);
      end else begin
        e = exp_q.pop_front();
        if (data[sel][HW-1:0] !== e) begin
          n_fail++;
          $display("FAIL pkt_hdr: got %0h expected %0h", data[sel][HW-1:0], e);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0; ready[i] = 1'b1; en[i] = 1'b1; wv[i] = 1'b0; wd[i] = '0;
    end
    ready[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", vld[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_sent", sent[0], 0);
    chk("rst_recv", recv[0], 0);
    chk("rst_err", errc[0], 0);
    chk("rst_lsum", lsum[0], 0);
    chk("rst_lmax", lmax[0], 0);
    chk("rst_data", |data[0], 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx(1'b0, 1'b0, 32'hFFFF_FFFE);
    chk("wrap_recv", recv[0], 1);
    chk("wrap_lsum", lsum[0], 5);
    chk("wrap_lmax", lmax[0], 5);
    chk("wrap_err", errc[0], 0);
    // east neighbour, one packet per cycle
    sel = 0;
    start[0] = 1'b1;
    c = tb_cyc;
    for (int k = 0; k < 4; k++) exp_q.push_back(hdr(1'b1, 1'b0, c + 1 + k, 16'(k)));
    repeat (5) @(negedge clk);
    chk("t1_done_early", done[0], 0);
    @(negedge clk);
    chk("t1_done", done[0], 1);
    chk("t1_sent", sent[0], 4);
    chk("t1_recv_clr", recv[0], 0);
    chk("t1_q", exp_q.size(), 0);
    rx(1'b0, 1'b0, tb_cyc - 7);
    chk("lat7_recv", recv[0], 1);
    chk("lat7_lsum", lsum[0], 7);
    chk("lat7_lmax", lmax[0], 7);
    chk("lat7_err", errc[0], 0);
    rx(1'b1, 1'b1, tb_cyc - 3);
    chk("mis_recv", recv[0], 2);
    chk("mis_err", errc[0], 1);
    chk("mis_lsum", lsum[0], 10);
    chk("mis_lmax", lmax[0], 7);
    // stop, restart with cleared counters, stop again mid-run
    start[0] = 1'b0;
    @(negedge clk);
    chk("stop_done", done[0], 0);
    chk("stop_valid", vld[0], 0);
    start[0] = 1'b1;
    c = tb_cyc;
    exp_q.push_back(hdr(1'b1, 1'b0, c + 1, 16'd0));
    exp_q.push_back(hdr(1'b1, 1'b0, c + 2, 16'd1));
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    chk("abort_valid", vld[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_sent", sent[0], 2);
    chk("abort_recv", recv[0], 0);
    chk("abort_q", exp_q.size(), 0);
    // RATE=4 with backpressure
    sel = 1;
    start[1] = 1'b1;
    c = tb_cyc;
    exp_q.push_back(hdr(1'b1, 1'b0, c + 1, 16'd0));
    repeat (2) @(negedge clk);
    chk("stall_first", vld[1], 1);
    save = data[1];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", vld[1], 1);
      chk("stall_data", data[1] == save, 1);
      chk("stall_sent", sent[1], 0);
    end
    ready[1] = 1'b1;
    c = tb_cyc;
    exp_q.push_back(hdr(1'b1, 1'b0, c, 16'd1));
    exp_q.push_back(hdr(1'b1, 1'b0, c + 4, 16'd2));
    repeat (2) @(negedge clk);
    chk("rate_gap", vld[1], 0);
    repeat (6) @(negedge clk);
    chk("r4_sent", sent[1], 3);
    chk("r4_done", done[1], 1);
    chk("r4_q", exp_q.size(), 0);
    start[1] = 1'b0;
    // bit complement
    sel = 2;
    start[2] = 1'b1;
    c = tb_cyc;
    exp_q.push_back(hdr(1'b1, 1'b1, c + 1, 16'd0));
    exp_q.push_back(hdr(1'b1, 1'b1, c + 2, 16'd1));
    repeat (6) @(negedge clk);
    chk("cmp_sent", sent[2], 2);
    chk("cmp_done", done[2], 1);
    chk("cmp_q", exp_q.size(), 0);
    start[2] = 1'b0;
    // transpose on the diagonal: every slot skipped
    sel = 3;
    start[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tr_valid", vld[3], 0);
    end
    chk("tr_done_early", done[3], 0);
    @(negedge clk);
    chk("tr_done", done[3], 1);
    chk("tr_sent", sent[3], 0);
    start[3] = 1'b0;
    // reset in the middle of a run
    sel = 0;
    start[0] = 1'b1;
    c = tb_cyc;
    exp_q.push_back(hdr(1'b1, 1'b0, c + 1, 16'd0));
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mrst_valid", vld[0], 0);
    chk("mrst_data", |data[0], 0);
    chk("mrst_sent", sent[0], 0);
    chk("mrst_recv", recv[0], 0);
    chk("mrst_err", errc[0], 0);
    chk("mrst_lsum", lsum[0], 0);
    chk("mrst_lmax", lmax[0], 0);
    chk("mrst_done", done[0], 0);
    start[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_q", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_traffic_pe.md
# noc_traffic_pe

Synthesizable per-node traffic generator and sink for the OpenNoc mesh, attached to one router's PE port in place of the behavioural random PE. It injects NUM_PACKETS packets at a programmable rate using one of four destination patterns, stamps each packet with source, sequence and injection time, and checks every ejected packet. Per-node statistics are kept in hardware for throughput, latency and misroute measurement: sent, received, latency sum, latency max and errors.

## Interface
- X, 2: mesh columns
- Y, 2: mesh rows
- x_size, $clog2(X): x-coordinate field width
- y_size, $clog2(Y): y-coordinate field width
- data_width, 256: payload width; must be ≥ TS_W+16+x_size+y_size
- MY_X, 0 / MY_Y, 0: this node's coordinates
- NUM_PACKETS, 1000: packets to inject per run (≤ 65535)
- RATE, 1: injection interval in cycles (≥ 1)
- PATTERN, 0: 0 random, 1 transpose (requires X==Y), 2 bit-complement, 3 east neighbour (x+1 mod X, same y)
- TS_W, 32: timestamp/cycle-counter width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; run enable
- enable_send  in  1  injection gate; 0 pauses injection only
- r_valid_pe  out  1  packet to NoC valid
- r_data_pe  out  x_size+y_size+data_width  packet to NoC
- r_ready_pe  in  1  NoC accepts packet
- w_valid_pe  in  1  packet from NoC valid (no backpressure)
- w_data_pe  in  x_size+y_size+data_width  packet from NoC
- done  out  1  all packets injected
- sent_count  out  16  packets accepted by NoC
- recv_count  out  16  packets ejected here
- lat_sum  out  48  sum of latencies of received packets
- lat_max  out  TS_W  max latency seen
- err_count  out  16  misrouted packets received

## Operation
- Packet format, LSB first: dest x [x_size], dest y [y_size], payload. Payload LSB first: timestamp [TS_W], seq [16], src x [x_size], src y [y_size], remaining bits LFSR fill.
- FSM: IDLE → RUN when start=1; RUN → DONE when sent_count+skipped == NUM_PACKETS and no packet held; any state → IDLE when start=0 (statistics retained, held packet dropped, r_valid_pe cleared). IDLE→RUN clears all counters and statistics.
- Rate counter in RUN, enable_send=1: counts RATE-1 down to 0; at 0, if holding register empty, loads a packet and reloads counter; if full, holds at 0 (no credit accumulation).
- Destination: random = 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 ^ node id) low bits; field value ≥ X (or Y) has X (or Y) subtracted; if result == self, x becomes (x+1) mod X. Transpose/complement yielding self: slot counted as skipped, no packet emitted. LFSR advances once per load.
- Transmit: r_valid_pe holds with stable data until r_ready_pe=1; sent_count increments on that handshake.
- Receive, every cycle w_valid_pe=1: recv_count++; latency = (cycle_cnt − timestamp) mod 2^TS_W; lat_sum += latency; lat_max updated; if dest field ≠ (MY_X,MY_Y) then err_count++ (latency still accumulated). Receive active in all states.
- done=1 in DONE only.

## Timing
- Reset: all outputs 0, FSM IDLE, cycle_cnt 0, LFSR seeded.
- cycle_cnt free-runs from reset, wraps at 2^TS_W.
- First packet: r_valid_pe rises on the first clock edge after the IDLE→RUN edge (RATE counter starts at 0).
- Load in same cycle as handshake permitted: with RATE=1 and r_ready_pe held 1, one packet per cycle.
- Statistics update one cycle after w_valid_pe sample (registered).
- Counters saturate at all-ones.

## Structure
- Shared package/include noc_traffic_defs: field offsets, PATTERN encodings, LFSR polynomial/seed.
- Sub-module noc_traffic_sink: receive path (latency, lat_sum/lat_max, err/recv counters); generator and FSM in top.

## Test plan
- 2x2, node (0,0), PATTERN=3, RATE=1, NUM_PACKETS=4, r_ready_pe=1 → four packets dest (1,0), seq 0..3, done on 5th cycle after start.
- RATE=4, r_ready_pe=1 → r_valid_pe pulses every 4 cycles; r_ready_pe=0 for 10 cycles → data stable, no extra packets, sent_count frozen.
- Inject w_valid_pe with timestamp = cycle_cnt−7, dest=self → recv_count=1, lat_sum=7, lat_max=7, err_count=0; dest=(1,1) → err_count=1.
- Timestamp wrap: cycle_cnt=3, timestamp=2^TS_W−2 → latency 5.
- PATTERN=2 on 2x2 node (0,0) → dest (1,1); PATTERN=1 node (0,0) → all skipped, no r_valid_pe, done after NUM_PACKETS rate slots.
- Deassert start mid-run → r_valid_pe=0 next cycle, IDLE; reassert → counters cleared, seq restarts at 0; rst mid-run → all outputs 0.
